// File: rtl/motor_pkg.sv
// motor_pkg: shared types and constants for the motor_drive_seq H-bridge
// sequencer. Holds the FSM state encoding, duty constants and the decoder
// that turns one switch bank into a duty value.
package motor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DECEL = 2'd2,
        DEAD  = 2'd3
    } state_t;

    localparam int DUTY_W    = 7;
    localparam int DUTY_MAX  = 100;
    localparam int PWM_STEPS = 100;

    localparam logic [DUTY_W-1:0] DUTY_100 = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] DUTY_75  = 7'd75;
    localparam logic [DUTY_W-1:0] DUTY_50  = 7'd50;
    localparam logic [DUTY_W-1:0] DUTY_25  = 7'd25;

    // Highest set switch index wins; [0]=100 %, [3]=25 %, all clear = 0 %.
    function automatic logic [DUTY_W-1:0] bank_to_duty(input logic [3:0] bank);
        logic [DUTY_W-1:0] duty;
        if (bank[3])      duty = DUTY_25;
        else if (bank[2]) duty = DUTY_50;
        else if (bank[1]) duty = DUTY_75;
        else if (bank[0]) duty = DUTY_100;
        else              duty = '0;
        return duty;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// pwm_gen: PWM engine for one bridge channel. A prescaler divides clk into
// PWM steps, a step counter runs 0..PWM_STEPS-1, o_boundary strobes on the
// cycle the counter wraps, and the output compare is registered.
module pwm_gen
    import motor_pkg::*;
#(
    parameter int unsigned PWM_PRESC = 40
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] i_duty,
    input  logic              i_force,
    output logic              o_boundary,
    output logic              o_pwm
);

    localparam int unsigned       PRESC_W    = (PWM_PRESC > 1) ? $clog2(PWM_PRESC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PWM_PRESC - 1);
    localparam logic [DUTY_W-1:0]  STEP_LAST  = DUTY_W'(PWM_STEPS - 1);

    logic [PRESC_W-1:0] r_presc;
    logic [DUTY_W-1:0]  r_step;
    logic               r_pwm;
    logic               w_step_adv;

    assign w_step_adv = (r_presc == PRESC_LAST);
    assign o_boundary = w_step_adv && (r_step == STEP_LAST);
    assign o_pwm      = r_pwm;

    // Prescaler, step counter and registered duty compare.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge values regardless of statement order.
        if (rst) begin
            r_presc <= '0;
            r_step  <= '0;
            r_pwm   <= 1'b0;
        end else begin
            r_presc <= w_step_adv ? '0 : r_presc + PRESC_W'(1);
            if (w_step_adv) begin
                r_step <= (r_step == STEP_LAST) ? '0 : r_step + DUTY_W'(1);
            end
            r_pwm <= i_force || (r_step < i_duty);
        end
    end

endmodule

// File: rtl/motor_drive_seq.sv
// motor_drive_seq: sequences one L298 H-bridge channel from forward/reverse
// switch banks. Synchronises and decodes the switches, ramps the duty toward
// the target, decelerates to zero and waits a dead time before reversing.
// Optional feature: define MOTOR_BRAKE_EN to drive fast brake (in1=in2=1,
// pwm high) in IDLE and DEAD instead of coasting.
module motor_drive_seq
    import motor_pkg::*;
#(
    parameter int unsigned PWM_PRESC   = 40,
    parameter int unsigned RAMP_DIV    = 100000,
    parameter int unsigned DEAD_CYC    = 500000,
    parameter int unsigned SYNC_STAGES = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        sw_fwd,
    input  logic [3:0]        sw_rev,
    output logic              in1,
    output logic              in2,
    output logic              pwm_out,
    output logic [DUTY_W-1:0] duty_cur,
    output logic              dir_cur,
    output logic              busy,
    output logic              conflict
);

    localparam int unsigned       RAMP_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned       DEAD_W    = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);

    logic [3:0]        r_sync_fwd [SYNC_STAGES];
    logic [3:0]        r_sync_rev [SYNC_STAGES];
    logic [RAMP_W-1:0] r_ramp_cnt;
    logic [DEAD_W-1:0] r_dead_cnt;
    logic [DUTY_W-1:0] r_duty_ramp;
    logic [DUTY_W-1:0] r_duty_cur;
    state_t            r_state;
    logic              r_dir_cur;
    logic              r_in1;
    logic              r_in2;
    logic              r_busy;

    logic [3:0]        w_fwd_bank;
    logic [3:0]        w_rev_bank;
    logic [DUTY_W-1:0] w_tgt_duty;
    logic              w_tgt_dir;
    logic              w_conflict;
    logic [DUTY_W-1:0] w_ramp_goal;
    logic [DUTY_W-1:0] w_ramp_next;
    logic              w_ramp_tick;
    logic              w_dead_done;
    logic              w_boundary;
    logic              w_pwm;
    state_t            w_state_next;
    logic              w_dir_next;
    logic              w_in1_next;
    logic              w_in2_next;
    logic              w_force;

    assign w_fwd_bank  = r_sync_fwd[SYNC_STAGES-1];
    assign w_rev_bank  = r_sync_rev[SYNC_STAGES-1];
    assign w_ramp_tick = (r_ramp_cnt == RAMP_LAST);
    assign w_dead_done = (r_state == DEAD) && (r_dead_cnt == DEAD_LAST);

    // Pick target duty/direction from the synchronised banks.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        w_tgt_duty = '0;
        w_tgt_dir  = r_dir_cur;
        w_conflict = (w_fwd_bank != 4'd0) && (w_rev_bank != 4'd0);
        if (w_fwd_bank != 4'd0 && w_rev_bank == 4'd0) begin
            w_tgt_duty = bank_to_duty(w_fwd_bank);
            w_tgt_dir  = 1'b1;
        end else if (w_rev_bank != 4'd0 && w_fwd_bank == 4'd0) begin
            w_tgt_duty = bank_to_duty(w_rev_bank);
            w_tgt_dir  = 1'b0;
        end
    end

    // Ramp one step toward the goal on each tick; only RUN in the current
    // direction ramps up, every other case heads to zero.
    always_comb begin
        w_ramp_goal = '0;
        if (r_state == RUN && w_tgt_dir == r_dir_cur) begin
            w_ramp_goal = w_tgt_duty;
        end
        w_ramp_next = r_duty_ramp;
        if (w_ramp_tick) begin
            if (r_duty_ramp < w_ramp_goal)      w_ramp_next = r_duty_ramp + DUTY_W'(1);
            else if (r_duty_ramp > w_ramp_goal) w_ramp_next = r_duty_ramp - DUTY_W'(1);
        end
    end

    // Next-state and next-direction logic.
    always_comb begin
        w_state_next = r_state;
        w_dir_next   = r_dir_cur;
        case (r_state)
            IDLE: begin
                if (w_tgt_duty != '0) begin
                    w_state_next = RUN;
                    w_dir_next   = w_tgt_dir;
                end
            end
            RUN: begin
                if (w_tgt_duty != '0 && w_tgt_dir != r_dir_cur) begin
                    w_state_next = DECEL;
                end else if (w_tgt_duty == '0 && r_duty_cur == '0 && r_duty_ramp == '0) begin
                    w_state_next = IDLE;
                end
            end
            DECEL: begin
                if (w_tgt_duty != '0 && w_tgt_dir == r_dir_cur) begin
                    w_state_next = RUN;
                end else if (w_boundary && r_duty_cur == '0 && r_duty_ramp == '0) begin
                    w_state_next = DEAD;
                end
            end
            DEAD: begin
                if (w_dead_done) begin
                    w_dir_next   = w_tgt_dir;
                    w_state_next = (w_tgt_duty != '0) ? RUN : IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Bridge pin and PWM-force decode from the next state, so pins switch on
    // the same edge as the state.
    always_comb begin
        w_in1_next = 1'b0;
        w_in2_next = 1'b0;
        w_force    = 1'b0;
        case (w_state_next)
            RUN, DECEL: begin
                w_in1_next = w_dir_next;
                w_in2_next = ~w_dir_next;
            end
            default: begin
`ifdef MOTOR_BRAKE_EN
                w_in1_next = 1'b1;
                w_in2_next = 1'b1;
                w_force    = 1'b1;
`else
                w_in1_next = 1'b0;
                w_in2_next = 1'b0;
                w_force    = 1'b0;
`endif
            end
        endcase
    end

    // Switch synchronisers.
    always_ff @(posedge clk) begin
        // NOTE: the synchroniser chain is cleared on reset so a stale switch
        // value cannot launch the motor straight out of reset.
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync_fwd[i] <= '0;
                r_sync_rev[i] <= '0;
            end
        end else begin
            r_sync_fwd[0] <= sw_fwd;
            r_sync_rev[0] <= sw_rev;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync_fwd[i] <= r_sync_fwd[i-1];
                r_sync_rev[i] <= r_sync_rev[i-1];
            end
        end
    end

    // Ramp/dead timers, duty registers, FSM state and registered pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ramp_cnt  <= '0;
            r_dead_cnt  <= '0;
            r_duty_ramp <= '0;
            r_duty_cur  <= '0;
            r_state     <= IDLE;
            r_dir_cur   <= 1'b1;
            r_in1       <= 1'b0;
            r_in2       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_ramp_cnt  <= w_ramp_tick ? '0 : r_ramp_cnt + RAMP_W'(1);
            r_dead_cnt  <= (r_state == DEAD) ? r_dead_cnt + DEAD_W'(1) : '0;
            r_duty_ramp <= w_ramp_next;
            if (w_boundary) begin
                r_duty_cur <= w_ramp_next;
            end
            r_state   <= w_state_next;
            r_dir_cur <= w_dir_next;
            r_in1     <= w_in1_next;
            r_in2     <= w_in2_next;
            r_busy    <= (w_state_next == DECEL) || (w_state_next == DEAD);
        end
    end

    pwm_gen #(
        .PWM_PRESC (PWM_PRESC)
    ) u_pwm_gen (
        .clk        (clk),
        .rst        (rst),
        .i_duty     (r_duty_cur),
        .i_force    (w_force),
        .o_boundary (w_boundary),
        .o_pwm      (w_pwm)
    );

    assign in1      = r_in1;
    assign in2      = r_in2;
    assign pwm_out  = w_pwm;
    assign duty_cur = r_duty_cur;
    assign dir_cur  = r_dir_cur;
    assign busy     = r_busy;
    assign conflict = w_conflict;

endmodule
